// File: rtl/mixer_seq_ctrl.sv
// Run sequencer for one rotary mixer ring: fill A, fill B, pump-mix for N rounds, then drain.
// Outputs are registered, so a new state shows one cycle after its cause; cmd_ready is high only in IDLE.
module mixer_seq_ctrl #(
  parameter int CNT_W     = 8,
  parameter int RND_W     = 6,
  parameter int PHASE_DIV = 4,
  parameter int DRAIN_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_fill_a,
  input  logic [CNT_W-1:0] cmd_fill_b,
  input  logic [RND_W-1:0] cmd_rounds,
  input  logic             abort,
  output logic             valve_in_a,
  output logic             valve_in_b,
  output logic             valve_out,
  output logic             valve_flush,
  output logic [2:0]       pump_phase,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int DRN_W = $clog2(DRAIN_CYC + 1);
  localparam int CW    = (CNT_W > DRN_W) ? CNT_W : DRN_W;
  localparam int DIV_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;

  typedef enum logic [2:0] {IDLE, FILL_A, FILL_B, MIX, DRAIN} state_t;

  state_t           state, nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [2:0]       step, step_nxt;
  logic [RND_W-1:0] rnd_left, rnd_nxt;
  logic [RND_W-1:0] rounds_q, rounds_eff;
  logic [CNT_W-1:0] fill_b_q, fill_b_eff;
  logic             abort_q;
  logic             accept;
  logic             abort_hit;
  logic             mix_last;

  function automatic logic [2:0] pump_pat(input logic [2:0] s);
    case (s)
      3'd0:    pump_pat = 3'b100;
      3'd1:    pump_pat = 3'b110;
      3'd2:    pump_pat = 3'b010;
      3'd3:    pump_pat = 3'b011;
      3'd4:    pump_pat = 3'b001;
      default: pump_pat = 3'b101;
    endcase
  endfunction

  assign accept     = cmd_valid && (state == IDLE);
  assign abort_hit  = abort && (state inside {FILL_A, FILL_B, MIX});
  // On acceptance the latched copies are not loaded yet, so entry loads read the live fields.
  assign fill_b_eff = (state == IDLE) ? cmd_fill_b : fill_b_q;
  assign rounds_eff = (state == IDLE) ? cmd_rounds : rounds_q;
  assign mix_last   = (div_cnt == '0) && (step == 3'd5) && (rnd_left == '0);

  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    div_nxt  = div_cnt;
    step_nxt = step;
    rnd_nxt  = rnd_left;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_fill_a != '0)      nxt = FILL_A;
          else if (cmd_fill_b != '0) nxt = FILL_B;
          else if (cmd_rounds != '0) nxt = MIX;
          else                       nxt = DRAIN;
        end
      end
      FILL_A: begin
        cnt_nxt = cnt - CW'(1);
        if (abort)              nxt = DRAIN;
        else if (cnt == '0) begin
          if (fill_b_q != '0)      nxt = FILL_B;
          else if (rounds_q != '0) nxt = MIX;
          else                     nxt = DRAIN;
        end
      end
      FILL_B: begin
        cnt_nxt = cnt - CW'(1);
        if (abort)          nxt = DRAIN;
        else if (cnt == '0) nxt = (rounds_q != '0) ? MIX : DRAIN;
      end
      MIX: begin
        if (div_cnt == '0) begin
          div_nxt = DIV_W'(PHASE_DIV - 1);
          if (step == 3'd5) begin
            step_nxt = 3'd0;
            rnd_nxt  = rnd_left - RND_W'(1);
          end else begin
            step_nxt = step + 3'd1;
          end
        end else begin
          div_nxt = div_cnt - DIV_W'(1);
        end
        if (abort || mix_last) nxt = DRAIN;
      end
      DRAIN: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == '0) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase

    // Counters are loaded with dwell-1 on entry so the state exits when they reach zero.
    if (nxt != state) begin
      case (nxt)
        FILL_A: cnt_nxt = CW'(cmd_fill_a) - CW'(1);
        FILL_B: cnt_nxt = CW'(fill_b_eff) - CW'(1);
        MIX: begin
          div_nxt  = DIV_W'(PHASE_DIV - 1);
          step_nxt = 3'd0;
          rnd_nxt  = rounds_eff - RND_W'(1);
        end
        DRAIN:   cnt_nxt = CW'(DRAIN_CYC - 1);
        default: cnt_nxt = cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      div_cnt     <= '0;
      step        <= '0;
      rnd_left    <= '0;
      fill_b_q    <= '0;
      rounds_q    <= '0;
      abort_q     <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      valve_in_a  <= 1'b0;
      valve_in_b  <= 1'b0;
      valve_out   <= 1'b0;
      valve_flush <= 1'b0;
      pump_phase  <= 3'b000;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= cnt_nxt;
      div_cnt  <= div_nxt;
      step     <= step_nxt;
      rnd_left <= rnd_nxt;

      if (accept) begin
        fill_b_q <= cmd_fill_b;
        rounds_q <= cmd_rounds;
        abort_q  <= 1'b0;
      end else if (abort_hit) begin
        abort_q  <= 1'b1;
      end

      cmd_ready   <= (nxt == IDLE);
      busy        <= (nxt != IDLE);
      valve_in_a  <= (nxt == FILL_A);
      valve_in_b  <= (nxt == FILL_B);
      valve_out   <= (nxt inside {FILL_A, FILL_B, DRAIN});
      valve_flush <= (nxt == DRAIN);
      pump_phase  <= (nxt == MIX) ? pump_pat(step_nxt) : 3'b000;
      done        <= (state == DRAIN) && (nxt == IDLE) && !abort_q;
      aborted     <= (state == DRAIN) && (nxt == IDLE) && abort_q;
    end
  end

endmodule

// File: tb/tb_mixer_seq_ctrl.sv
// Bench for mixer_seq_ctrl: per-cycle output traces built from the run rules, compared every cycle.
module tb_mixer_seq_ctrl;
  localparam int CNT_W = 8;
  localparam int RND_W = 6;
  localparam int PD    = 2;
  localparam int DC    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_fill_a;
  logic [CNT_W-1:0] cmd_fill_b;
  logic [RND_W-1:0] cmd_rounds;
  logic             abort;
  logic             valve_in_a, valve_in_b, valve_out, valve_flush;
  logic [2:0]       pump_phase;
  logic             busy, done, aborted;

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];
  int drain_lo;

  mixer_seq_ctrl #(.CNT_W(CNT_W), .RND_W(RND_W), .PHASE_DIV(PD), .DRAIN_CYC(DC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fill_a(cmd_fill_a), .cmd_fill_b(cmd_fill_b), .cmd_rounds(cmd_rounds),
    .abort(abort), .valve_in_a(valve_in_a), .valve_in_b(valve_in_b),
    .valve_out(valve_out), .valve_flush(valve_flush), .pump_phase(pump_phase),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Vector order: ready, busy, in_a, in_b, out, flush, pump[2:0], done, aborted
  function automatic logic [10:0] obs();
    return {cmd_ready, busy, valve_in_a, valve_in_b, valve_out, valve_flush,
            pump_phase, done, aborted};
  endfunction

  function automatic logic [10:0] idle_v(input logic d, input logic a);
    return {1'b1, 1'b0, 4'b0000, 3'b000, d, a};
  endfunction

  function automatic logic [2:0] pat(input int i);
    case (i)
      0:       return 3'b100;
      1:       return 3'b110;
      2:       return 3'b010;
      3:       return 3'b011;
      4:       return 3'b001;
      default: return 3'b101;
    endcase
  endfunction

  task automatic build(input int fa, input int fb, input int r, input int k);
    int pre;
    bit ab;
    exp_q.delete();
    for (int i = 0; i < fa; i++) exp_q.push_back({2'b01, 4'b1010, 3'b000, 2'b00});
    for (int i = 0; i < fb; i++) exp_q.push_back({2'b01, 4'b0110, 3'b000, 2'b00});
    for (int j = 0; j < r * 6 * PD; j++)
      exp_q.push_back({2'b01, 4'b0000, pat((j / PD) % 6), 2'b00});
    pre = exp_q.size();
    ab = 1'b0;
    if (k > 0 && k <= pre) begin
      while (exp_q.size() > k) void'(exp_q.pop_back());
      ab = 1'b1;
    end
    drain_lo = exp_q.size();
    for (int i = 0; i < DC; i++) exp_q.push_back({2'b01, 4'b0011, 3'b000, 2'b00});
    exp_q.push_back(idle_v(!ab, ab));
  endtask

  // Entered at #1 after a rising edge with the DUT in an IDLE cycle; returns likewise.
  task automatic run(input string name, input int fa, input int fb, input int r, input int k,
                     input int stop_at, input bit hold, input bit ab_acc, input bit ab_drain);
    int n;
    build(fa, fb, r, k);
    cmd_valid  = 1'b1;
    cmd_fill_a = CNT_W'(fa);
    cmd_fill_b = CNT_W'(fb);
    cmd_rounds = RND_W'(r);
    abort      = ab_acc;
    n = (stop_at > 0) ? stop_at : exp_q.size();
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      total++;
      if (obs() !== exp_q[c-1]) begin
        bad++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, c, obs(), exp_q[c-1]);
      end
      cmd_valid  = hold;
      cmd_fill_a = CNT_W'($urandom_range(0, 255));
      cmd_fill_b = CNT_W'($urandom_range(0, 255));
      cmd_rounds = RND_W'($urandom_range(0, 63));
      abort = (c == k) ||
              (ab_drain && c > drain_lo && c <= drain_lo + DC && $urandom_range(0, 1) == 1);
    end
    abort = 1'b0;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      abort = $urandom_range(0, 1) == 1;
      @(posedge clk); #1;
      total++;
      if (obs() !== idle_v(1'b0, 1'b0)) begin
        bad++;
        $display("FAIL idle cycle %0d: got %b expected %b", c, obs(), idle_v(1'b0, 1'b0));
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; abort = 1'b1;
    cmd_fill_a = 8'd3; cmd_fill_b = 8'd3; cmd_rounds = 6'd1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs() !== idle_v(1'b0, 1'b0)) begin
      bad++;
      $display("FAIL reset_state: got %b expected %b", obs(), idle_v(1'b0, 1'b0));
    end
    rst = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    run("basic_3_2_1", 3, 2, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_empty();
    run("empty_0_0_0", 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run("only_b_0_5_0", 0, 5, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run("only_mix_0_0_2", 0, 0, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_abort();
    run("abort_mix5", 1, 1, 3, 7, 0, 1'b0, 1'b0, 1'b0);
    run("abort_fill_a", 4, 2, 1, 2, 0, 1'b0, 1'b0, 1'b0);
    run("abort_fill_b_last", 1, 3, 0, 4, 0, 1'b0, 1'b0, 1'b0);
    run("abort_in_drain", 1, 0, 1, 15, 0, 1'b0, 1'b0, 1'b1);
    run("abort_on_accept", 2, 0, 1, 0, 0, 1'b0, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    run("b2b_first", 2, 1, 1, 0, 0, 1'b1, 1'b0, 1'b0);
    run("b2b_second", 3, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_reset_mid();
    run("rst_mid_fill_b", 2, 5, 1, 0, 4, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs() !== idle_v(1'b0, 1'b0)) begin
      bad++;
      $display("FAIL rst_mid_state: got %b expected %b", obs(), idle_v(1'b0, 1'b0));
    end
    rst = 1'b0;
    idle(1);
    run("after_rst", 1, 2, 1, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_max_rounds();
    run("max_rounds", 0, 0, 63, 0, 0, 1'b0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int fa, fb, r, k;
      fa = $urandom_range(0, 5);
      fb = $urandom_range(0, 5);
      r  = $urandom_range(0, 3);
      k  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, fa + fb + r * 6 * PD + DC) : 0;
      run("random", fa, fb, r, k, 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_fill_a = '0; cmd_fill_b = '0; cmd_rounds = '0;
    test_reset();
    test_basic();
    test_empty();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_max_rounds();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
